// File: rtl/reg_sel_decoder_pkg.sv
// Shared register-file constants and the decoder state encoding.
package reg_sel_decoder_pkg;

    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned REG_COUNT  = 16;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/reg_sel_decoder_if.sv
// Request/decode bus between the writeback/control side and the register-select decoder.
interface reg_sel_decoder_if
    import reg_sel_decoder_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_ADDR_W
) ();

    logic                     wr_valid;
    logic [ADDR_W-1:0]        wr_addr;
    logic                     wr_ready;
    logic                     clr_req;
    logic                     clr_busy;
    logic [(1<<ADDR_W)-1:0]   dec_out;
    logic [ADDR_W-1:0]        dec_addr;
    logic                     dec_valid;

    modport master (
        output wr_valid, wr_addr, clr_req,
        input  wr_ready, clr_busy, dec_out, dec_addr, dec_valid
    );

    modport slave (
        input  wr_valid, wr_addr, clr_req,
        output wr_ready, clr_busy, dec_out, dec_addr, dec_valid
    );

endinterface

// File: rtl/reg_sel_decoder_onehot_dec.sv
// Purely combinational binary-index to one-hot decoder.
module onehot_dec #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic [ADDR_W-1:0]      idx,
    output logic [(1<<ADDR_W)-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/reg_sel_decoder.sv
// Registered register-select decoder with a one-per-cycle clear sequencer.
// Optional REG_SEL_ZERO_PROTECT_EN: normal writes to r0 produce no enable.
module reg_sel_decoder
    import reg_sel_decoder_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    reg_sel_decoder_if.slave  bus
);

    localparam int unsigned N = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] sel_idx;
    logic [N-1:0]      onehot;
    logic [N-1:0]      out_q, out_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              ready;

    assign ready = (state_q == S_IDLE) && !bus.clr_req;

    // cnt_q is 0 whenever idle, so a starting clear decodes r0 in its request cycle.
    assign sel_idx = (state_q == S_CLEAR || bus.clr_req) ? cnt_q : bus.wr_addr;

    onehot_dec #(
        .ADDR_W (ADDR_W)
    ) u_onehot_dec (
        .idx    (sel_idx),
        .onehot (onehot)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = '0;
        addr_d  = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.clr_req) begin
                    out_d   = onehot;
                    addr_d  = cnt_q;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = cnt_q + ADDR_W'(1);
                    state_d = S_CLEAR;
                end else if (bus.wr_valid) begin
`ifdef REG_SEL_ZERO_PROTECT_EN
                    if (bus.wr_addr != '0) begin
                        out_d   = onehot;
                        addr_d  = bus.wr_addr;
                        valid_d = 1'b1;
                    end
`else
                    out_d   = onehot;
                    addr_d  = bus.wr_addr;
                    valid_d = 1'b1;
`endif
                end
            end
            S_CLEAR: begin
                out_d   = onehot;
                addr_d  = cnt_q;
                valid_d = 1'b1;
                busy_d  = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.wr_ready  = ready;
    assign bus.dec_out   = out_q;
    assign bus.dec_addr  = addr_q;
    assign bus.dec_valid = valid_q;
    assign bus.clr_busy  = busy_q;

endmodule

// File: tb/tb_reg_sel_decoder.sv
// Self-checking bench for reg_sel_decoder: directed table, corner sequences, random vs queue model.
module tb_reg_sel_decoder;
    import reg_sel_decoder_pkg::*;

    localparam int unsigned N = REG_COUNT;
`ifdef REG_SEL_ZERO_PROTECT_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_sel_decoder_if bus ();

    reg_sel_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: a clear request loads the list of registers still to be enabled.
    int unsigned  clr_q[$];
    logic [N-1:0] m_out;
    logic [3:0]   m_addr;
    logic         m_valid;
    logic         m_busy;

    typedef struct {
        logic        rst;
        logic        v;
        logic [3:0]  a;
        logic        c;
        logic [15:0] exp_out;
        logic        exp_valid;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [3:0] a, input logic c);
        int unsigned idx;
        m_out   = '0;
        m_addr  = '0;
        m_valid = 1'b0;
        m_busy  = 1'b0;
        if (r) begin
            clr_q.delete();
        end else begin
            if (clr_q.size() == 0 && c) begin
                for (int i = 0; i < int'(N); i++) clr_q.push_back(i);
            end
            if (clr_q.size() != 0) begin
                idx          = clr_q.pop_front();
                m_out[idx]   = 1'b1;
                m_addr       = 4'(idx);
                m_valid      = 1'b1;
                m_busy       = 1'b1;
            end else if (v && !(ZP && a == 4'd0)) begin
                m_out[a] = 1'b1;
                m_addr   = a;
                m_valid  = 1'b1;
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] a, input logic c,
                        output logic rdy);
        reset        = r;
        bus.wr_valid = v;
        bus.wr_addr  = a;
        bus.clr_req  = c;
        #1;
        rdy = bus.wr_ready;
        if (!r) chk("wr_ready", 32'(bus.wr_ready), 32'(clr_q.size() == 0 && !c));
        @(posedge clk);
        model_edge(r, v, a, c);
        #1;
        chk("dec_out",   32'(bus.dec_out),   32'(m_out));
        chk("dec_addr",  32'(bus.dec_addr),  32'(m_addr));
        chk("dec_valid", 32'(bus.dec_valid), 32'(m_valid));
        chk("clr_busy",  32'(bus.clr_busy),  32'(m_busy));
        chk("onehot_max1", 32'($countones(bus.dec_out) <= 1), 32'd1);
        chk("invalid_zero", 32'(!bus.dec_valid && bus.dec_out != '0), 32'd0);
    endtask

    initial begin
        logic rdy;
        vecs[0] = '{1'b1, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 4'hA, 1'b0, 16'h0400, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 4'h3, 1'b0, 16'h0008, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 4'hF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 4'h7, 1'b0, 16'h0080, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 4'h0, 1'b0, ZP ? 16'h0000 : 16'h0001, !ZP, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b1};

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].rst, vecs[i].v, vecs[i].a, vecs[i].c, rdy);
            if (!vecs[i].rst) chk("tbl_ready", 32'(rdy), 32'(vecs[i].exp_ready));
            chk("tbl_out", 32'(bus.dec_out), 32'(vecs[i].exp_out));
            chk("tbl_valid", 32'(bus.dec_valid), 32'(vecs[i].exp_valid));
        end

        // Plain clear pulse: walk r0..r15, then a write is accepted.
        step(1'b0, 1'b0, 4'h0, 1'b1, rdy);
        chk("clr_start_ready", 32'(rdy), 32'd0);
        chk("clr_walk", 32'(bus.dec_out), 32'h0001);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 1'b0, 4'h0, 1'b0, rdy);
            chk("clr_walk", 32'(bus.dec_out), 32'h1 << i);
            chk("clr_busy_walk", 32'(bus.clr_busy), 32'd1);
        end
        step(1'b0, 1'b1, 4'h2, 1'b0, rdy);
        chk("ready_after_clear", 32'(rdy), 32'd1);
        chk("write_after_clear", 32'(bus.dec_out), 32'h0004);
        chk("busy_after_clear", 32'(bus.clr_busy), 32'd0);

        // Clear and write in the same cycle: clear wins, write held and ignored throughout.
        step(1'b0, 1'b1, 4'h5, 1'b1, rdy);
        chk("clr_wins_ready", 32'(rdy), 32'd0);
        chk("clr_wins_out", 32'(bus.dec_out), 32'h0001);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 1'b1, 4'h5, 1'b1, rdy);
            chk("clr_wins_ready_walk", 32'(rdy), 32'd0);
            chk("clr_wins_walk", 32'(bus.dec_out), 32'h1 << i);
        end
        step(1'b0, 1'b0, 4'h0, 1'b0, rdy);
        chk("clr_wins_end", 32'(bus.dec_out), 32'h0);

        // Reset at clear step 6 aborts the walk.
        step(1'b0, 1'b0, 4'h0, 1'b1, rdy);
        for (int i = 1; i <= 6; i++) step(1'b0, 1'b0, 4'h0, 1'b0, rdy);
        chk("step6_out", 32'(bus.dec_out), 32'h0040);
        step(1'b1, 1'b0, 4'h0, 1'b0, rdy);
        chk("abort_out", 32'(bus.dec_out), 32'h0);
        chk("abort_busy", 32'(bus.clr_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 4'h0, 1'b0, rdy);
            chk("abort_no_resume", 32'(bus.dec_out), 32'h0);
            chk("abort_ready", 32'(rdy), 32'd1);
        end

        // Randomised traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) == 0, 1'($urandom), 4'($urandom),
                 $urandom_range(0, 24) == 0, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
